// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state codes,
// ALU/mux select constants and the control-word layout.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // ADDI only decodes when the optional immediate-add path is built in.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_MC_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State-to-control-word decode for the multicycle MIPS controller.
// ADDIEX/ADDIWB decode only when MIPS_MC_ADDI_EN is defined.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       op_ok,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.illegal_op = ~op_ok;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // Strobes stay up through the whole wait; completion is flagged on the ready cycle.
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.aluop         = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multicycle MIPS datapath. Define MIPS_MC_ADDI_EN to
// add the ADDIEX/ADDIWB immediate-add path; otherwise opcode 001000 is illegal.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_ok;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_out;

    assign op_ok = op_supported(opcode);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)                state_d = S_RTYPEEX;
                else if (opcode == OP_BEQ)                  state_d = S_BEQEX;
                else if (opcode == OP_J)                    state_d = S_JEX;
`ifdef MIPS_MC_ADDI_EN
                else if (opcode == OP_ADDI)                 state_d = S_ADDIEX;
`endif
                else                                        state_d = S_FETCH;
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .op_ok     (op_ok),
        .ctrl      (ctrl_raw)
    );

    // Reset masks the decode combinationally so no strobe survives an abort.
    assign ctrl_out = reset ? '0 : ctrl_raw;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign iord          = ctrl_out.iord;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign aluop         = ctrl_out.aluop;
    assign pc_source     = ctrl_out.pc_source;
    assign illegal_op    = ctrl_out.illegal_op;
    assign instr_done    = ctrl_out.instr_done;
    assign state         = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM that sequences the multicycle MIPS datapath: register file, ALU, PC/IR registers and unified memory.
- Decodes the 6-bit opcode latched in IR and steps through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit aluop consumed by alu_control, plus all mux selects and write enables.
- Handles memory wait states through a mem_ready handshake.

Parameters:
- none (encodings fixed in package)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write data select: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination register select: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluop  out  2  to alu_control: 00=add, 01=sub, 10=funct
- pc_source  out  2  PC source select: 00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- state  out  4  current state, debug

Behaviour:
- Reset: state=FETCH asynchronously. While reset=1, every output except state is forced to 0.
- Outputs are a combinational decode of the state register. Outputs not listed for a state are 0.
- FETCH(0): mem_read=1, alu_src_b=01, aluop=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE(1): alu_src_b=11, aluop=00. Transitions by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 000010 (j) -> JEX
  - 001000 (addi) -> ADDIEX, only with the feature enabled
  - any other opcode -> illegal_op=1 and return to FETCH; no architectural write.
- MEMADR(2): alu_src_a=1, alu_src_b=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(3): iord=1, mem_read=1. Holds until mem_ready, then MEMWB.
- MEMWB(4): mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWR(5): iord=1, mem_write=1. Holds until mem_ready; then instr_done=1 -> FETCH.
- RTYPEEX(6): alu_src_a=1, alu_src_b=00, aluop=10 -> RTYPEWB.
- RTYPEWB(7): reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
- BEQEX(8): alu_src_a=1, aluop=01, pc_source=01, pc_write_cond=1, instr_done=1 -> FETCH.
- JEX(9): pc_source=10, pc_write=1, instr_done=1 -> FETCH.
- Latency with mem_ready tied to 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - Each stall cycle adds 1.
- Strobes in waiting states stay constant while mem_ready=0; the address source does not change mid-access.
- A mem_ready pulse in a non-memory state is ignored.
- Unused state encodings (12-15) -> FETCH next cycle, all outputs 0.
- Reset asserted mid-instruction aborts it immediately; no partial write strobe is issued after reset.

Optional Feature:
- MIPS_MC_ADDI_EN defined: adds ADDIEX(10) and ADDIWB(11).
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, aluop=00.
  - ADDIWB(11): reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
- Not defined: opcode 001000 is illegal (illegal_op pulse, back to FETCH); encodings 10-11 are treated as unused.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - 4-bit state encodings
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - alu_src_b and pc_source select constants
- Sub-module mips_ctrl_outdec: pure state-to-control-word decode. The top module keeps the state register, next-state logic and reset gating.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1 -> all outputs 0 during reset; first cycle after release shows state=0, mem_read=1, ir_write=1, pc_write=1.
- lw (100011), mem_ready=1 -> states 0,1,2,3,4; aluop=00 in state 2; reg_write=1 with mem_to_reg=1 in state 4; instr_done asserted once.
- R-type (000000) -> aluop=10 in state 6; reg_dst=1, reg_write=1 in state 7; back to FETCH after 4 cycles.
- sw (101011) with mem_ready low for 2 cycles in MEMWR -> mem_write=1 and iord=1 held 3 cycles; instr_done only on the third.
- beq then j -> state 8 shows aluop=01, pc_write_cond=1, pc_source=01; state 9 shows pc_write=1, pc_source=10; each takes 3 cycles.
- Opcode 001000 with and without MIPS_MC_ADDI_EN; reset asserted while in MEMRD -> enabled: states 10,11 with reg_write=1, reg_dst=0; disabled: illegal_op pulse, next state 0; reset in MEMRD: state=0 and mem_read=0 immediately, without waiting for a clock edge.
